// File: rtl/wb_direct_cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache: FSM encoding,
// address field positions and block geometry.
package wb_direct_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WBACK = 2'd1,
        ST_ALLOC = 2'd2
    } state_e;

    localparam int OFS_LSB   = 0;
    localparam int IDX_LSB   = 2;
    localparam int OFS_W     = 2;
    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 4;
    localparam int BLK_W     = WORD_W * BLK_WORDS;
    localparam int PADDR_W   = 30;
    localparam int MADDR_W   = 28;

endpackage

// File: rtl/wb_direct_cache_if.sv
// Core-side and memory-side signals of the cache, bundled as one interface.
// The master modport is the environment (core + memory), slave is the cache.
interface wb_direct_cache_if;
    import wb_direct_cache_pkg::*;

    logic                 proc_read;
    logic                 proc_write;
    logic [PADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]    proc_wdata;
    logic [WORD_W-1:0]    proc_rdata;
    logic                 proc_stall;
    logic                 mem_read;
    logic                 mem_write;
    logic [MADDR_W-1:0]   mem_addr;
    logic [BLK_W-1:0]     mem_wdata;
    logic [BLK_W-1:0]     mem_rdata;
    logic                 mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/wb_direct_cache_line_array.sv
// Line storage: valid/dirty/tag/data registers, word-write merge, word read mux.
// Only valid/dirty are reset; tag and data are qualified by valid.
module cache_line_array
    import wb_direct_cache_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    localparam int IDX_W      = $clog2(NUM_BLOCKS),
    localparam int TAG_W      = MADDR_W - IDX_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [OFS_W-1:0]   i_ofs,
    input  logic               i_wr_word,
    input  logic [WORD_W-1:0]  i_wdata,
    input  logic               i_fill,
    input  logic [BLK_W-1:0]   i_fill_data,
    input  logic               i_clr_dirty,
    output logic               o_hit,
    output logic [WORD_W-1:0]  o_rdata,
    output logic               o_victim_dirty,
    output logic [TAG_W-1:0]   o_victim_tag,
    output logic [BLK_W-1:0]   o_victim_line
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLK_W-1:0]      r_data [NUM_BLOCKS];

    logic [6:0]            w_word_lsb;
    logic [BLK_W-1:0]      w_line;

    assign w_word_lsb = {i_ofs, 5'd0};
    assign w_line     = r_data[i_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_wr_word) begin
            r_dirty[i_idx] <= 1'b1;
        end else if (i_clr_dirty) begin
            r_dirty[i_idx] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_data;
        end else if (i_wr_word) begin
            r_data[i_idx][w_word_lsb +: WORD_W] <= i_wdata;
        end
    end

    assign o_hit          = r_valid[i_idx] & (r_tag[i_idx] == i_tag);
    assign o_rdata        = w_line[w_word_lsb +: WORD_W];
    assign o_victim_dirty = r_valid[i_idx] & r_dirty[i_idx];
    assign o_victim_tag   = r_tag[i_idx];
    assign o_victim_line  = w_line;

endmodule

// File: rtl/wb_direct_cache.sv
// Direct-mapped, write-back, write-allocate cache between the core and a
// 128-bit block memory; stalls the core while a miss is serviced.
module wb_direct_cache
    import wb_direct_cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_direct_cache_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = MADDR_W - IDX_W;

    state_e               r_state;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [MADDR_W-1:0]   r_mem_addr;
    logic [BLK_W-1:0]     r_mem_wdata;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [OFS_W-1:0]     w_ofs;
    logic                 w_req;
    logic                 w_idle;
    logic                 w_hit;
    logic                 w_wr_word;
    logic                 w_fill;
    logic                 w_clr_dirty;
    logic [WORD_W-1:0]    w_rword;
    logic                 w_victim_dirty;
    logic [TAG_W-1:0]     w_victim_tag;
    logic [BLK_W-1:0]     w_victim_line;

    assign w_idx       = bus.proc_addr[IDX_LSB +: IDX_W];
    assign w_tag       = bus.proc_addr[PADDR_W-1 -: TAG_W];
    assign w_ofs       = bus.proc_addr[OFS_LSB +: OFS_W];
    assign w_req       = bus.proc_read | bus.proc_write;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_word   = w_idle & w_hit & bus.proc_write;
    assign w_fill      = (r_state == ST_ALLOC) & bus.mem_ready;
    assign w_clr_dirty = (r_state == ST_WBACK) & bus.mem_ready;

    cache_line_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_lines (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_idx          (w_idx),
        .i_tag          (w_tag),
        .i_ofs          (w_ofs),
        .i_wr_word      (w_wr_word),
        .i_wdata        (bus.proc_wdata),
        .i_fill         (w_fill),
        .i_fill_data    (bus.mem_rdata),
        .i_clr_dirty    (w_clr_dirty),
        .o_hit          (w_hit),
        .o_rdata        (w_rword),
        .o_victim_dirty (w_victim_dirty),
        .o_victim_tag   (w_victim_tag),
        .o_victim_line  (w_victim_line)
    );

    // Memory-side outputs are loaded on state entry so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_hit) begin
                        if (w_victim_dirty) begin
                            r_state     <= ST_WBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_victim_tag, w_idx};
                            r_mem_wdata <= w_victim_line;
                        end else begin
                            r_state    <= ST_ALLOC;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_tag, w_idx};
                        end
                    end
                end
                ST_WBACK: begin
                    if (bus.mem_ready) begin
                        r_state     <= ST_ALLOC;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= {w_tag, w_idx};
                    end
                end
                ST_ALLOC: begin
                    if (bus.mem_ready) begin
                        r_state    <= ST_IDLE;
                        r_mem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    // Hits release the core in the same cycle; reset forces the stall low.
    assign bus.proc_stall = rst_n & ~(w_idle & (~w_req | w_hit));
    assign bus.proc_rdata = (w_idle & w_hit & bus.proc_read & ~bus.proc_write) ? w_rword : '0;

endmodule

// File: tb/tb_wb_direct_cache.sv
// Directed bench for wb_direct_cache: fills, hits, write-back eviction,
// clean eviction, reset mid-miss, spurious mem_ready, read+write overlap.
module tb_wb_direct_cache;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic both_seen;
    logic write_seen;

    localparam logic [127:0] L0 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L0W = 128'h44444444_DEADBEEF_22222222_11111111;
    localparam logic [127:0] L1 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;

    wb_direct_cache_if bus ();

    wb_direct_cache #(.NUM_BLOCKS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_read && bus.mem_write) both_seen = 1'b1;
        if (bus.mem_write) write_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle completion pulse, then let outputs settle for checking.
    task automatic mem_pulse(input logic [127:0] data);
        bus.mem_rdata = data;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        both_seen = 1'b0;
        write_seen = 1'b0;
        rst_n = 1'b0;
        bus.proc_read = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_stall", bus.proc_stall, 0);
        chk("rst_rdata", bus.proc_rdata, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;

        // Cold read miss of 0x10 -> block 4
        tick();
        set_req(1, 0, 30'h10, 0);
        chk("miss_stall", bus.proc_stall, 1);
        tick();
        chk("alloc_mem_read", bus.mem_read, 1);
        chk("alloc_mem_write", bus.mem_write, 0);
        chk("alloc_mem_addr", bus.mem_addr, 28'h4);
        chk("alloc_stall", bus.proc_stall, 1);
        repeat (4) tick();
        mem_pulse(L0);
        chk("fill_stall", bus.proc_stall, 0);
        chk("fill_rdata", bus.proc_rdata, 32'h11111111);
        chk("fill_mem_read", bus.mem_read, 0);

        // Same-line hit
        set_req(1, 0, 30'h11, 0);
        chk("hit_stall", bus.proc_stall, 0);
        chk("hit_rdata", bus.proc_rdata, 32'h22222222);

        // Write hit, then read back
        tick();
        set_req(0, 1, 30'h12, 32'hDEADBEEF);
        chk("wr_hit_stall", bus.proc_stall, 0);
        tick();
        set_req(1, 0, 30'h12, 0);
        chk("wr_rd_stall", bus.proc_stall, 0);
        chk("wr_rd_rdata", bus.proc_rdata, 32'hDEADBEEF);
        chk("wr_mem_read", bus.mem_read, 0);
        chk("wr_mem_write", bus.mem_write, 0);

        // Spurious mem_ready with no request
        tick();
        set_req(0, 0, 30'h32, 0);
        bus.mem_rdata = {4{32'hBADBAD00}};
        bus.mem_ready = 1'b1;
        #1;
        chk("spur_stall", bus.proc_stall, 0);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("spur_mem_read", bus.mem_read, 0);
        chk("spur_mem_write", bus.mem_write, 0);
        set_req(1, 0, 30'h12, 0);
        chk("spur_keep_stall", bus.proc_stall, 0);
        chk("spur_keep_rdata", bus.proc_rdata, 32'hDEADBEEF);

        // Dirty eviction: 0x32 conflicts with dirty block 4
        tick();
        set_req(1, 0, 30'h32, 0);
        chk("dirty_miss_stall", bus.proc_stall, 1);
        tick();
        chk("wb_mem_write", bus.mem_write, 1);
        chk("wb_mem_read", bus.mem_read, 0);
        chk("wb_mem_addr", bus.mem_addr, 28'h4);
        chk("wb_word2", bus.mem_wdata[95:64], 32'hDEADBEEF);
        chk("wb_line", bus.mem_wdata, L0W);
        tick();
        chk("wb_hold_stall", bus.proc_stall, 1);
        chk("wb_hold_addr", bus.mem_addr, 28'h4);
        mem_pulse(0);
        chk("wb2alloc_write", bus.mem_write, 0);
        chk("wb2alloc_read", bus.mem_read, 1);
        chk("wb2alloc_addr", bus.mem_addr, 28'hC);
        chk("wb2alloc_stall", bus.proc_stall, 1);
        tick();
        mem_pulse(L1);
        chk("evict_stall", bus.proc_stall, 0);
        chk("evict_rdata", bus.proc_rdata, 32'hCCCC0002);

        // Clean eviction: straight to ALLOC, no write-back
        tick();
        write_seen = 1'b0;
        set_req(1, 0, 30'h10, 0);
        chk("clean_miss_stall", bus.proc_stall, 1);
        tick();
        chk("clean_mem_write", bus.mem_write, 0);
        chk("clean_mem_read", bus.mem_read, 1);
        chk("clean_mem_addr", bus.mem_addr, 28'h4);
        mem_pulse(L0);
        chk("clean_rdata", bus.proc_rdata, 32'h11111111);
        chk("clean_stall", bus.proc_stall, 0);
        chk("clean_no_wback", write_seen, 0);

        // Reset in the middle of ALLOC
        tick();
        set_req(1, 0, 30'h32, 0);
        tick();
        chk("mid_alloc_read", bus.mem_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_read", bus.mem_read, 0);
        chk("async_mem_addr", bus.mem_addr, 0);
        chk("async_stall", bus.proc_stall, 0);
        set_req(0, 0, 30'h0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        set_req(1, 0, 30'h10, 0);
        chk("post_rst_miss", bus.proc_stall, 1);
        tick();
        chk("post_rst_read", bus.mem_read, 1);
        chk("post_rst_addr", bus.mem_addr, 28'h4);
        mem_pulse(L0);
        chk("post_rst_rdata", bus.proc_rdata, 32'h11111111);

        // Read and write together behaves as a write
        tick();
        set_req(1, 1, 30'h13, 32'h12345678);
        chk("rw_stall", bus.proc_stall, 0);
        tick();
        set_req(1, 0, 30'h13, 0);
        chk("rw_rdata", bus.proc_rdata, 32'h12345678);
        chk("rw_mem_write", bus.mem_write, 0);

        tick();
        set_req(0, 0, 30'h0, 0);
        chk("rw_exclusive", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
